// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU1 operand-interface driver.
// Flag bit positions match the {ERR,OFLOW,COUT,G,L,E} ordering of rsp_flags.
package alu_drv_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int FLAG_W     = 6;
  localparam int FLAG_E     = 0;
  localparam int FLAG_L     = 1;
  localparam int FLAG_G     = 2;
  localparam int FLAG_COUT  = 3;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_ERR   = 5;

  localparam logic MODE_ARITH = 1'b1;
  localparam logic MODE_LOGIC = 1'b0;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic err, input logic oflow,
                                                   input logic cout, input logic g,
                                                   input logic l, input logic e);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_ERR]   = err;
    f[FLAG_OFLOW] = oflow;
    f[FLAG_COUT]  = cout;
    f[FLAG_G]     = g;
    f[FLAG_L]     = l;
    f[FLAG_E]     = e;
    return f;
  endfunction

endpackage

// File: rtl/alu_lat_timer.sv
// Down-counter that times the ALU latency; loaded with LAT-1 on the issue cycle.
// zero is high once the counter has run out, marking the result-capture edge.
module alu_lat_timer #(
  parameter int LAT = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic zero
);

  localparam int TW = $clog2(LAT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_op_driver.sv
// Initiator for the ALU1 operand interface: one request in, one CE pulse out,
// result captured after LAT cycles and returned on a valid/ready response.
module alu_op_driver
  import alu_drv_pkg::*;
#(
  parameter int INPUT = 8,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INPUT-1:0]      req_opa,
  input  logic [INPUT-1:0]      req_opb,
  input  logic                  req_cin,
  input  logic [3:0]            req_cmd,
  input  logic                  req_mode,
  input  logic [1:0]            req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*INPUT-1:0]    rsp_res,
  output logic [FLAG_W-1:0]     rsp_flags,
  output logic [INPUT-1:0]      alu_opa,
  output logic [INPUT-1:0]      alu_opb,
  output logic                  alu_cin,
  output logic                  alu_mode,
  output logic                  alu_ce,
  output logic [3:0]            alu_cmd,
  output logic [1:0]            alu_valid,
  input  logic [2*INPUT-1:0]    alu_res,
  input  logic                  alu_err,
  input  logic                  alu_oflow,
  input  logic                  alu_cout,
  input  logic                  alu_g,
  input  logic                  alu_l,
  input  logic                  alu_e,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  state_t state;
  logic   accept;
  logic   timer_zero;

  // In RESP a new request may only be taken on the edge the response retires.
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  alu_lat_timer #(.LAT(LAT)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .load (state == ISSUE),
    .zero (timer_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      alu_opa   <= '0;
      alu_opb   <= '0;
      alu_cin   <= 1'b0;
      alu_mode  <= 1'b0;
      alu_cmd   <= '0;
      alu_valid <= '0;
      alu_ce    <= 1'b0;
      rsp_res   <= '0;
      rsp_flags <= '0;
      ops_done  <= '0;
    end else begin
      alu_ce <= 1'b0;
      // The captured request lives directly in the alu_* registers, so operands
      // stay stable from the CE cycle until the next accepted request.
      if (accept) begin
        alu_opa   <= req_opa;
        alu_opb   <= req_opb;
        alu_cin   <= req_cin;
        alu_mode  <= req_mode;
        alu_cmd   <= req_cmd;
        alu_valid <= req_sel;
        alu_ce    <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) state <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (timer_zero) begin
            rsp_res   <= alu_res;
            rsp_flags <= pack_flags(alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done <= ops_done + CNT_W'(1);
            state    <= accept ? ISSUE : IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver with a behavioural ALU1 stub of latency LAT.
// Table vectors, hand sequences for stall/back-to-back/reset, and random ops vs a scoreboard.
module tb_alu_op_driver;
  import alu_drv_pkg::*;

  localparam int INPUT = 8;
  localparam int LAT   = 3;
  localparam int CNT_W = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              req_valid, req_ready;
  logic [7:0]        req_opa, req_opb;
  logic              req_cin, req_mode;
  logic [3:0]        req_cmd;
  logic [1:0]        req_sel;
  logic              rsp_valid, rsp_ready;
  logic [15:0]       rsp_res;
  logic [5:0]        rsp_flags;
  logic [7:0]        alu_opa, alu_opb;
  logic              alu_cin, alu_mode, alu_ce;
  logic [3:0]        alu_cmd;
  logic [1:0]        alu_valid;
  logic [15:0]       alu_res;
  logic              alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
  logic              busy;
  logic [CNT_W-1:0]  ops_done;

  alu_op_driver #(.INPUT(INPUT), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
    .req_cmd(req_cmd), .req_mode(req_mode), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
    .alu_mode(alu_mode), .alu_ce(alu_ce), .alu_cmd(alu_cmd), .alu_valid(alu_valid),
    .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // ALU1 behaviour: {res[15:0], err, oflow, cout, g, l, e}
  function automatic logic [21:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic [1:0] sel);
    logic [15:0] r;
    logic err, of, co, g, l, e;
    int s;
    err = (sel != 2'b11);
    of = 1'b0; co = 1'b0; g = 1'b0; l = 1'b0; e = 1'b0;
    if (mode == MODE_ARITH && cmd == 4'd0) begin
      s  = int'(a) + int'(b) + int'(cin);
      r  = 16'(s);
      co = (s > 255);
      of = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      if (mode == MODE_ARITH) r = (cmd == 4'd1) ? 16'(int'(a) * int'(b)) : {a, b};
      else begin
        case (cmd)
          4'd0:    r = {8'h00, a & b};
          4'd1:    r = {8'h00, a | b};
          4'd2:    r = {8'h00, a ^ b};
          default: r = {8'h00, ~a};
        endcase
      end
      g = (a > b); l = (a < b); e = (a == b);
    end
    return {r, err, of, co, g, l, e};
  endfunction

  // ALU stub: result valid only on the edge LAT cycles after the CE edge, garbage otherwise.
  logic        stub_ce;
  logic [21:0] stub_v, stub_pend;
  int          stub_left = -1;
  always @(posedge CLK) begin
    stub_ce = alu_ce;
    stub_v  = alu_fn(alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin, alu_valid);
    #1;
    if (stub_ce) begin
      stub_pend = stub_v;
      stub_left = LAT - 1;
    end else if (stub_left >= 0) begin
      stub_left--;
    end
    {alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} =
      (stub_left == 0) ? stub_pend : {16'hDEAD, 6'b101010};
  end

  // Scoreboard / protocol monitor, sampled on the falling edge.
  typedef struct {
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] a, b;
    logic       cin;
    logic [1:0] sel;
  } req_t;

  req_t        req_q[$];
  logic [21:0] exp_q[$];
  int          ce_cyc[$];
  int          cyc = 0;
  int          ce_total = 0;
  int          ops_model = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_res;
  logic [5:0]  prev_flags;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    req_t        r;
    logic [21:0] x;
    if (RST) begin
      req_q.delete();
      exp_q.delete();
      ops_model = 0;
      prev_hold = 1'b0;
    end else begin
      check("ops_done", 32'(ops_done), 32'(ops_model));
      if (prev_hold) begin
        check("rsp_valid_held", 32'(rsp_valid), 32'd1);
        check("rsp_stable", {10'd0, rsp_res, rsp_flags}, {10'd0, prev_res, prev_flags});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) timeout("unexpected_rsp");
        else begin
          x = exp_q.pop_front();
          check("rsp_res", 32'(rsp_res), 32'(x[21:6]));
          check("rsp_flags", 32'(rsp_flags), 32'(x[5:0]));
        end
        ops_model = (ops_model + 1) % (1 << CNT_W);
      end
      if (req_valid && req_ready) begin
        r = '{req_mode, req_cmd, req_opa, req_opb, req_cin, req_sel};
        req_q.push_back(r);
        exp_q.push_back(alu_fn(req_mode, req_cmd, req_opa, req_opb, req_cin, req_sel));
      end
      if (alu_ce) begin
        ce_total++;
        ce_cyc.push_back(cyc);
        if (req_q.size() == 0) timeout("unexpected_ce");
        else begin
          r = req_q.pop_front();
          check("alu_issue",
                {8'd0, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin, alu_valid},
                {8'd0, r.mode, r.cmd, r.a, r.b, r.cin, r.sel});
        end
      end
      prev_hold  = rsp_valid && !rsp_ready;
      prev_res   = rsp_res;
      prev_flags = rsp_flags;
    end
  end

  typedef struct {
    logic        mode;
    logic [3:0]  cmd;
    logic [7:0]  a, b;
    logic        cin;
    logic [1:0]  sel;
    logic [15:0] exp_res;
    logic [5:0]  exp_flags;
  } vec_t;

  task automatic drive(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic [1:0] sel);
    req_mode = mode; req_cmd = cmd; req_opa = a; req_opb = b; req_cin = cin; req_sel = sel;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (req_valid && req_ready) begin
        ok = 1'b1;
        return;
      end
    end
    timeout("accept");
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      lat++;
      if (rsp_valid) return;
    end
    timeout("rsp_valid");
  endtask

  initial begin
    vec_t vecs[9];
    bit   ok;
    int   lat, ce0, n0, o0, seen;

    vecs[0] = '{MODE_ARITH, 4'd0, 8'd50,  8'd25,  1'b0, 2'b11, 16'd75,   6'b000000};
    vecs[1] = '{MODE_ARITH, 4'd0, 8'd1,   8'd1,   1'b0, 2'b11, 16'd2,    6'b000000};
    vecs[2] = '{MODE_ARITH, 4'd0, 8'd200, 8'd100, 1'b1, 2'b11, 16'd301,  6'b001000};
    vecs[3] = '{MODE_ARITH, 4'd0, 8'd100, 8'd100, 1'b0, 2'b11, 16'd200,  6'b010000};
    vecs[4] = '{MODE_ARITH, 4'd0, 8'd50,  8'd25,  1'b0, 2'b00, 16'd75,   6'b100000};
    vecs[5] = '{MODE_LOGIC, 4'd2, 8'hF0,  8'h3C,  1'b0, 2'b11, 16'h00CC, 6'b000100};
    vecs[6] = '{MODE_ARITH, 4'd1, 8'd12,  8'd13,  1'b0, 2'b01, 16'd156,  6'b100010};
    vecs[7] = '{MODE_LOGIC, 4'd0, 8'h55,  8'h55,  1'b0, 2'b11, 16'h0055, 6'b000001};
    vecs[8] = '{MODE_ARITH, 4'd5, 8'h12,  8'h34,  1'b0, 2'b11, 16'h1234, 6'b000010};

    RST = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 2'b00);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_ce", 32'(alu_ce), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_ops", {8'd0, alu_opa, alu_opb, alu_cin, alu_mode, alu_cmd, alu_valid}, 32'd0);
    check("rst_rsp", {10'd0, rsp_res, rsp_flags}, 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Single ops: latency, one CE pulse, captured result and flags.
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      drive(vecs[i].mode, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel);
      req_valid = 1'b1; rsp_ready = 1'b1;
      ce0 = ce_total;
      wait_accept(ok);
      @(posedge CLK); #1 req_valid = 1'b0;
      wait_rsp(lat);
      check("latency", 32'(lat), 32'(LAT + 2));
      check("ce_pulses", 32'(ce_total - ce0), 32'd1);
      check("vec_res", 32'(rsp_res), 32'(vecs[i].exp_res));
      check("vec_flags", 32'(rsp_flags), 32'(vecs[i].exp_flags));
      @(posedge CLK); #1 rsp_ready = 1'b0;
    end

    // Consumer stall: response held, no new request taken, one count on release.
    @(posedge CLK); #1;
    drive(MODE_ARITH, 4'd0, 8'd50, 8'd25, 1'b0, 2'b11);
    req_valid = 1'b1; rsp_ready = 1'b0;
    wait_accept(ok);
    @(posedge CLK); #1;
    wait_rsp(lat);
    o0 = ops_model;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_res", 32'(rsp_res), 32'd75);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    @(posedge CLK); #1 rsp_ready = 1'b1;
    @(posedge CLK); #1 rsp_ready = 1'b0;
    @(negedge CLK);
    check("stall_ops_once", 32'(ops_done), 32'((o0 + 1) % (1 << CNT_W)));
    check("stall_released", 32'(rsp_valid), 32'd0);

    // Back-to-back with req_valid and rsp_ready held high.
    @(posedge CLK); #1;
    drive(MODE_ARITH, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
    req_valid = 1'b1; rsp_ready = 1'b1;
    n0 = ce_cyc.size();
    wait_accept(ok);
    @(posedge CLK); #1 drive(MODE_ARITH, 4'd0, 8'd50, 8'd25, 1'b0, 2'b11);
    wait_accept(ok);
    check("b2b_first_res", {15'd0, rsp_valid, rsp_res}, {15'd0, 1'b1, 16'd2});
    @(posedge CLK); #1 req_valid = 1'b0;
    wait_rsp(lat);
    check("b2b_second_res", 32'(rsp_res), 32'd75);
    @(posedge CLK); #1 rsp_ready = 1'b0;
    if (ce_cyc.size() >= n0 + 2) check("b2b_ce_gap", 32'(ce_cyc[n0+1] - ce_cyc[n0]), 32'(LAT + 2));
    else timeout("b2b_ce_count");

    // Reset while waiting on the ALU.
    @(posedge CLK); #1;
    drive(MODE_ARITH, 4'd0, 8'd7, 8'd9, 1'b0, 2'b11);
    req_valid = 1'b1; rsp_ready = 1'b1;
    wait_accept(ok);
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_alu_ce", 32'(alu_ce), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_ops_done", 32'(ops_done), 32'd0);

    // 17 random ops with random consumer stalls; 4-bit counter wraps to 1.
    for (int k = 0; k < 17; k++) begin
      @(posedge CLK); #1;
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      req_valid = 1'b1; rsp_ready = 1'b0;
      wait_accept(ok);
      @(posedge CLK); #1 req_valid = 1'b0;
      wait_rsp(lat);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      @(posedge CLK); #1 rsp_ready = 1'b1;
      @(posedge CLK); #1 rsp_ready = 1'b0;
    end
    @(negedge CLK);
    check("wrap_ops_done", 32'(ops_done), 32'd1);
    check("no_pending_rsp", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
